// File: rtl/eth_mii_frame_tx.sv
// eth_mii_frame_tx: MII/GMII Ethernet frame transmitter.
// Adds preamble/SFD, pads short frames, appends CRC-32 FCS, keeps the IFG.
module eth_mii_frame_tx #(
  parameter int TXD_W          = 4,
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter bit FCS_EN         = 1'b1,
  parameter int IFG_BYTES      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  input  logic             last_in,
  output logic             ready_out,
  output logic [TXD_W-1:0] txd,
  output logic             tx_en,
  output logic             tx_er,
  output logic             busy
);

  localparam int          BPC      = 8 / TXD_W;
  localparam logic [7:0]  PRE_B    = 8'h55;
  localparam logic [7:0]  SFD_B    = 8'hD5;
  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] FCS_LAST = 16'd3;

  // ERR is the one byte time of tx_er signalling after an underrun.
  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ERR, IFG
  } state_t;

  state_t      state;
  logic        beat;
  logic        last_beat;
  logic [15:0] cnt;
  logic [15:0] sent;
  logic [15:0] sent_inc;
  logic [7:0]  data_q;
  logic        last_q;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [31:0] fcs_sr;
  logic [7:0]  cur_byte;

  // Select the beat-th TXD_W slice of a byte, low bits first.
  function automatic logic [TXD_W-1:0] nib(
    input logic [7:0] b,
    input logic       hi
  );
    logic [7:0] s;
    s = hi ? (b >> TXD_W) : b;
    return s[TXD_W-1:0];
  endfunction

  // Reflected CRC-32 over one TXD_W slice, LSB first.
  function automatic logic [31:0] crc_step(
    input logic [31:0]      c,
    input logic [TXD_W-1:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < TXD_W; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign last_beat = (BPC == 1) || beat;
  assign busy      = (state != IDLE);
  assign sent_inc  = (sent == 16'hFFFF) ? sent : sent + 16'd1;

  assign ready_out = last_beat &&
                     ((state == SFD) || (state == DATA && !last_q));

  // CRC absorbs whatever DATA/PAD slice is on txd this cycle.
  assign crc_nxt = (state == DATA || state == PAD) ?
                   crc_step(crc, txd) : crc;

  // Byte currently on the wire, used for the upper slice in MII mode.
  always_comb begin
    cur_byte = 8'h00;
    unique case (1'b1)
      state == PREAMBLE: cur_byte = PRE_B;
      state == SFD:      cur_byte = SFD_B;
      state == DATA:     cur_byte = data_q;
      default:           cur_byte = 8'h00;
    endcase
  end

  // Frame FSM; txd/tx_en/tx_er are loaded for the cycle being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= 1'b0;
      cnt    <= '0;
      sent   <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      crc    <= '0;
      fcs_sr <= '0;
      txd    <= '0;
      tx_en  <= 1'b0;
      tx_er  <= 1'b0;
    end else begin
      crc <= crc_nxt;
      if (state == IDLE) begin
        if (valid_in) begin
          state <= PREAMBLE;
          beat  <= 1'b0;
          cnt   <= '0;
          sent  <= '0;
          crc   <= CRC_INIT;
          tx_en <= 1'b1;
          tx_er <= 1'b0;
          txd   <= nib(PRE_B, 1'b0);
        end
      end else if (ready_out) begin
        beat <= 1'b0;
        if (valid_in) begin
          state  <= DATA;
          data_q <= data_in;
          last_q <= last_in;
          sent   <= sent_inc;
          txd    <= nib(data_in, 1'b0);
        end else begin
          state <= ERR;
          tx_er <= 1'b1;
          txd   <= '0;
        end
      end else if (!last_beat) begin
        beat <= 1'b1;
        if (state == FCS) begin
          fcs_sr <= fcs_sr >> TXD_W;
          txd    <= fcs_sr[2*TXD_W-1:TXD_W];
        end else begin
          txd <= nib(cur_byte, 1'b1);
        end
      end else begin
        beat <= 1'b0;
        unique case (state)
          PREAMBLE: begin
            if (cnt == PRE_LAST) begin
              state <= SFD;
              cnt   <= '0;
              txd   <= nib(SFD_B, 1'b0);
            end else begin
              cnt <= cnt + 16'd1;
              txd <= nib(PRE_B, 1'b0);
            end
          end
          DATA, PAD: begin
            if (sent < MIN_LEN) begin
              state <= PAD;
              sent  <= sent_inc;
              txd   <= '0;
            end else if (FCS_EN) begin
              state  <= FCS;
              cnt    <= '0;
              fcs_sr <= ~crc_nxt;
              txd    <= ~crc_nxt[TXD_W-1:0];
            end else begin
              state <= IFG;
              cnt   <= '0;
              tx_en <= 1'b0;
              txd   <= '0;
            end
          end
          FCS: begin
            if (cnt == FCS_LAST) begin
              state <= IFG;
              cnt   <= '0;
              tx_en <= 1'b0;
              txd   <= '0;
            end else begin
              cnt    <= cnt + 16'd1;
              fcs_sr <= fcs_sr >> TXD_W;
              txd    <= fcs_sr[2*TXD_W-1:TXD_W];
            end
          end
          ERR: begin
            state <= IFG;
            cnt   <= '0;
            tx_en <= 1'b0;
            tx_er <= 1'b0;
            txd   <= '0;
          end
          IFG: begin
            if (cnt != IFG_LAST) begin
              cnt <= cnt + 16'd1;
            end else if (valid_in) begin
              state <= PREAMBLE;
              cnt   <= '0;
              sent  <= '0;
              crc   <= CRC_INIT;
              tx_en <= 1'b1;
              tx_er <= 1'b0;
              txd   <= nib(PRE_B, 1'b0);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_mii_frame_tx.sv
// tb_eth_mii_frame_tx: three configurations (MII, MII no-pad, GMII)
// checked against a byte-list frame model with a plain CRC-32.
module tb_eth_mii_frame_tx;

  typedef struct packed {
    logic       v;
    logic       r;
    logic       b;
    logic       en;
    logic       er;
    logic [7:0] d;
  } smp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       vin;
  logic       lin;
  int         cur;

  logic       vin0, vin1, vin2;
  logic       rdy0, rdy1, rdy2;
  logic       en0, en1, en2;
  logic       er0, er1, er2;
  logic       bsy0, bsy1, bsy2;
  logic [3:0] txd0, txd1;
  logic [7:0] txd2;

  logic [7:0] pay_q[$];
  logic [8:0] exp_q[$];
  int         exp_len[$];
  smp_t       lg[$];
  smp_t       s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign vin0 = vin && (cur == 0);
  assign vin1 = vin && (cur == 1);
  assign vin2 = vin && (cur == 2);

  eth_mii_frame_tx u0 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin0),
    .last_in(lin), .ready_out(rdy0), .txd(txd0), .tx_en(en0),
    .tx_er(er0), .busy(bsy0)
  );

  eth_mii_frame_tx #(.MIN_FRAME(0)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin1),
    .last_in(lin), .ready_out(rdy1), .txd(txd1), .tx_en(en1),
    .tx_er(er1), .busy(bsy1)
  );

  eth_mii_frame_tx #(.TXD_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .valid_in(vin2),
    .last_in(lin), .ready_out(rdy2), .txd(txd2), .tx_en(en2),
    .tx_er(er2), .busy(bsy2)
  );

  always_comb begin
    s = '0;
    case (cur)
      0:       s = {vin0, rdy0, bsy0, en0, er0, 4'h0, txd0};
      1:       s = {vin1, rdy1, bsy1, en1, er1, 4'h0, txd1};
      default: s = {vin2, rdy2, bsy2, en2, er2, txd2};
    endcase
  end

  always @(negedge clk) lg.push_back(s);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    lg.delete();
    exp_q.delete();
    exp_len.delete();
  endtask

  task automatic rand_pay(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Expected tx_en burst: list of bytes, then split into PHY slices.
  task automatic model(input int w, input int minf, input bit fcs,
                       input int drop);
    logic [7:0]  b[$];
    logic [31:0] c;
    int          n, nb, base;
    n = (drop >= 0) ? drop : pay_q.size();
    for (int i = 0; i < 7; i++) b.push_back(8'h55);
    b.push_back(8'hD5);
    for (int i = 0; i < n; i++) b.push_back(pay_q[i]);
    if (drop < 0) begin
      nb = pay_q.size();
      while (nb < minf) begin
        b.push_back(8'h00);
        nb++;
      end
      if (fcs) begin
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < b.size(); i++) begin
          c = c ^ {24'h0, b[i]};
          for (int j = 0; j < 8; j++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
      end
    end
    base = exp_q.size();
    foreach (b[i]) begin
      if (w == 4) begin
        exp_q.push_back({5'h00, b[i][3:0]});
        exp_q.push_back({5'h00, b[i][7:4]});
      end else begin
        exp_q.push_back({1'b0, b[i]});
      end
    end
    if (drop >= 0) repeat (8 / w) exp_q.push_back(9'h100);
    exp_len.push_back(exp_q.size() - base);
  endtask

  // Feed pay_q with valid/ready; drop valid on accept of index drop.
  task automatic send(input int drop, input bit keep);
    int idx, n, t;
    bit acc, dropped;
    n = pay_q.size();
    idx = 0;
    t = 0;
    dropped = 1'b0;
    vin = 1'b1;
    while (idx < n && t < 3000 && !dropped) begin
      din = pay_q[idx];
      lin = (idx == n - 1);
      if (s.r && idx == drop) begin
        vin = 1'b0;
        dropped = 1'b1;
      end
      acc = s.r && vin;
      @(posedge clk);
      #2;
      t++;
      if (acc) idx++;
    end
    chk("send_done", (idx == n) || dropped, 1);
    if (!keep) vin = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (s.b && t < 3000) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("idle_reached", s.b, 0);
    repeat (4) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic smp_t at(input int i);
    if (i < 0 || i >= lg.size()) return '0;
    return lg[i];
  endfunction

  function automatic int first_en();
    foreach (lg[i]) if (lg[i].en) return i;
    return -1;
  endfunction

  function automatic int first_v();
    foreach (lg[i]) if (lg[i].v) return i;
    return -1;
  endfunction

  function automatic int first_r();
    foreach (lg[i]) if (lg[i].r) return i;
    return -1;
  endfunction

  // Walk logged bursts against the expected bursts, optional gap check.
  task automatic check_all(input string tag, input int gap);
    int p, st, prev_end, e, bad, len;
    p = 0;
    e = 0;
    prev_end = -1;
    for (int f = 0; f < exp_len.size(); f++) begin
      st = p;
      while (st < lg.size() && !lg[st].en) st++;
      len = 0;
      bad = 0;
      while (st + len < lg.size() && lg[st + len].en) begin
        if (len < exp_len[f] &&
            {lg[st + len].er, lg[st + len].d} !== exp_q[e + len]) bad++;
        len++;
      end
      chk($sformatf("%s_f%0d_len", tag, f), len, exp_len[f]);
      chk($sformatf("%s_f%0d_data", tag, f), bad, 0);
      if (gap >= 0 && f > 0)
        chk($sformatf("%s_f%0d_gap", tag, f), st - prev_end, gap);
      e += exp_len[f];
      prev_end = st + len;
      p = st + len;
    end
  endtask

  task automatic check_quiet(input string tag);
    int bad;
    bad = 0;
    foreach (lg[i]) if (!lg[i].en && (lg[i].d != 0 || lg[i].er)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n;
    logic [3:0] fv[8];
    fv = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    rst_n = 1'b0;
    vin = 1'b0;
    din = 8'h00;
    lin = 1'b0;
    cur = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_en", s.en, 0);
    chk("rst_er", s.er, 0);
    chk("rst_txd", s.d, 0);
    chk("rst_rdy", s.r, 0);
    chk("rst_busy", s.b, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    clear();
    pay_q = '{8'hAB};
    model(4, 60, 1, -1);
    send(-1, 0);
    wait_idle();
    check_all("pad", -1);
    st = first_en();
    chk("pre_latency", st - first_v(), 1);
    chk("rdy_pos", first_r() - st, 15);
    chk("pre_last", at(st + 14).d, 8'h05);
    chk("sfd_nib", at(st + 15).d, 8'h0D);
    chk("d0_lo", at(st + 16).d, 8'h0B);
    chk("d0_hi", at(st + 17).d, 8'h0A);
    check_quiet("pad_quiet");

    for (int i = 0; i < 3; i++) begin
      clear();
      rand_pay($urandom_range(1, 90));
      model(4, 60, 1, -1);
      send(-1, 0);
      wait_idle();
      check_all($sformatf("rnd0_%0d", i), -1);
    end

    clear();
    rand_pay(20);
    model(4, 60, 1, 2);
    send(2, 0);
    rand_pay($urandom_range(1, 10));
    model(4, 60, 1, -1);
    send(-1, 0);
    wait_idle();
    check_all("unr", 24);
    n = 0;
    foreach (lg[i]) if (lg[i].er) n++;
    chk("unr_er_cycles", n, 2);
    check_quiet("unr_quiet");

    clear();
    din = 8'h3C;
    lin = 1'b0;
    vin = 1'b1;
    repeat (24) @(posedge clk);
    #2;
    chk("mid_en", s.en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", s.en, 0);
    chk("mid_rst_er", s.er, 0);
    chk("mid_rst_txd", s.d, 0);
    chk("mid_rst_rdy", s.r, 0);
    chk("mid_rst_busy", s.b, 0);
    vin = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    clear();
    rand_pay(10);
    model(4, 60, 1, -1);
    send(-1, 0);
    wait_idle();
    check_all("post_rst", -1);

    cur = 1;
    clear();
    pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
              8'h36, 8'h37, 8'h38, 8'h39};
    model(4, 0, 1, -1);
    send(-1, 0);
    wait_idle();
    check_all("crcvec", -1);
    st = first_en();
    for (int k = 0; k < 8; k++)
      chk($sformatf("fcs_nib%0d", k), at(st + 34 + k).d, {4'h0, fv[k]});
    for (int i = 0; i < 2; i++) begin
      clear();
      rand_pay($urandom_range(1, 30));
      model(4, 0, 1, -1);
      send(-1, 0);
      wait_idle();
      check_all($sformatf("rnd1_%0d", i), -1);
    end

    cur = 2;
    clear();
    for (int i = 0; i < 3; i++) begin
      rand_pay($urandom_range(1, 70));
      model(8, 60, 1, -1);
      send(-1, i < 2);
    end
    wait_idle();
    check_all("b2b", 12);
    check_quiet("b2b_quiet");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
